// File: rtl/axis_maxpool_fp_2x2_if.sv
// Single-beat stream bus (32-bit float payload) shared by the pooling input and output sides.
// Handshake is the usual valid/ready pair; tlast marks the final beat of a frame.
interface axis_maxpool_fp_2x2_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_maxpool_fp_2x2.sv
// 2x2 stride-2 max pooling of a raster IEEE-754 single stream; 1-cycle latency from the completing beat.
// Input ready = output register empty or draining; one line buffer of horizontal pair maxima.
module axis_maxpool_fp_2x2 #(
  parameter int IMG_W = 638,
  parameter int IMG_H = 478
) (
  input logic                   s_axis_aclk,
  input logic                   s_axis_aresetn,
  axis_maxpool_fp_2x2_if.slave  s_axis,
  axis_maxpool_fp_2x2_if.master m_axis
);

  localparam int OUT_W = IMG_W / 2;
  localparam int OUT_H = IMG_H / 2;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int LBW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  // Float ordering key: positives above negatives, negatives reversed by inversion.
  function automatic logic [31:0] fkey(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  // Ties keep the first operand, so callers pass the earlier pixel as a.
  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [31:0]    pair_q, pair_d;
  logic [31:0]    dat_q, dat_d;
  logic           vld_q, vld_d;
  logic           last_q, last_d;
  logic [31:0]    lb_q [OUT_W];

  logic           s_rdy;
  logic           accept;
  logic           out_fire;
  logic           col_last;
  logic           row_last;
  logic           lb_we;
  logic           completing;
  logic [LBW-1:0] lb_idx;
  logic [31:0]    lb_rd;
  logic [31:0]    pair_max;
  logic [31:0]    win_max;

  assign s_rdy    = s_axis_aresetn & (~vld_q | m_axis.tready);
  assign accept   = s_axis.tvalid & s_rdy;
  assign out_fire = vld_q & m_axis.tready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));

  // Odd columns/rows are always inside the pooled area; the trailing column or
  // row of an odd-sized frame has even index and never writes or completes.
  assign lb_idx     = LBW'(col_q >> 1);
  assign lb_rd      = lb_q[lb_idx];
  assign pair_max   = fmax(pair_q, s_axis.tdata);
  assign win_max    = fmax(lb_rd, pair_max);
  assign lb_we      = accept & col_q[0] & ~row_q[0];
  assign completing = accept & col_q[0] & row_q[0];

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    pair_d = pair_q;
    dat_d  = dat_q;
    vld_d  = vld_q;
    last_d = last_q;

    if (out_fire) begin
      vld_d = 1'b0;
    end

    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (!col_q[0]) begin
        pair_d = s_axis.tdata;
      end
    end

    // A completing beat overrides the drain so the register reloads without a bubble.
    if (completing) begin
      dat_d  = win_max;
      vld_d  = 1'b1;
      last_d = (row_q == RW'(2 * OUT_H - 1)) && (col_q == CW'(2 * OUT_W - 1));
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
      dat_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      pair_q <= pair_d;
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Line buffer is written in every even row before the odd row reads it.
  always_ff @(posedge s_axis_aclk) begin
    if (lb_we) begin
      lb_q[lb_idx] <= pair_max;
    end
  end

  assign s_axis.tready = s_rdy;
  assign m_axis.tdata  = dat_q;
  assign m_axis.tvalid = vld_q;
  assign m_axis.tlast  = last_q;

endmodule

// File: tb/tb_axis_maxpool_fp_2x2.sv
// Directed bench for the 2x2 float max-pool: 4x4, 5x5 and 7x6 instances share clock and reset.
`timescale 1ns/1ps
module tb_axis_maxpool_fp_2x2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] s_dat [3];
  logic        s_vld [3];
  logic        m_rdy [3];
  logic        s_rdy [3];
  logic        m_vld [3];
  logic [31:0] m_dat [3];
  logic        m_last [3];

  logic [31:0] got_d [$];
  bit          got_l [$];

  axis_maxpool_fp_2x2_if s0 ();
  axis_maxpool_fp_2x2_if m0 ();
  axis_maxpool_fp_2x2_if s1 ();
  axis_maxpool_fp_2x2_if m1 ();
  axis_maxpool_fp_2x2_if s2 ();
  axis_maxpool_fp_2x2_if m2 ();

  assign s0.tdata = s_dat[0];  assign s0.tvalid = s_vld[0];  assign s0.tlast = 1'b0;  assign m0.tready = m_rdy[0];
  assign s1.tdata = s_dat[1];  assign s1.tvalid = s_vld[1];  assign s1.tlast = 1'b0;  assign m1.tready = m_rdy[1];
  assign s2.tdata = s_dat[2];  assign s2.tvalid = s_vld[2];  assign s2.tlast = 1'b0;  assign m2.tready = m_rdy[2];
  assign s_rdy[0] = s0.tready; assign m_vld[0] = m0.tvalid; assign m_dat[0] = m0.tdata; assign m_last[0] = m0.tlast;
  assign s_rdy[1] = s1.tready; assign m_vld[1] = m1.tvalid; assign m_dat[1] = m1.tdata; assign m_last[1] = m1.tlast;
  assign s_rdy[2] = s2.tready; assign m_vld[2] = m2.tvalid; assign m_dat[2] = m2.tdata; assign m_last[2] = m2.tlast;

  axis_maxpool_fp_2x2 #(.IMG_W(4), .IMG_H(4)) u0 (.s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis(s0), .m_axis(m0));
  axis_maxpool_fp_2x2 #(.IMG_W(5), .IMG_H(5)) u1 (.s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis(s1), .m_axis(m1));
  axis_maxpool_fp_2x2 #(.IMG_W(7), .IMG_H(6)) u2 (.s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis(s2), .m_axis(m2));

  // Exact float encoding of a small positive integer.
  function automatic logic [31:0] int2f(input int n);
    int          e;
    logic [31:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [31:0] okey(input logic [31:0] x);
    if (x[31]) return ~x;
    return x | 32'h8000_0000;
  endfunction

  task automatic drive(input int k, input logic [31:0] vals [$], input int gap);
    bit acc;
    int t;
    foreach (vals[i]) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        s_vld[k] = 1'b0;
        @(posedge clk); #1;
      end
      s_vld[k] = 1'b1;
      s_dat[k] = vals[i];
      acc = 1'b0;
      t = 0;
      while (!acc && t < 1000) begin
        @(negedge clk);
        acc = s_rdy[k];
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        n_chk++; n_fail++;
        $display("FAIL drive_timeout: inst %0d beat %0d not accepted, required accepted", k, i);
        break;
      end
    end
    s_vld[k] = 1'b0;
  endtask

  // mode 0: always ready; 1: one cycle ready then three stalled; 2: random.
  task automatic collect(input int k, input int n, input int mode);
    int          cyc;
    bit          stalled;
    logic [31:0] hd;
    logic        hl;
    got_d.delete();
    got_l.delete();
    cyc = 0;
    stalled = 1'b0;
    hd = '0;
    hl = 1'b0;
    m_rdy[k] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    while (got_d.size() < n && cyc < 5000) begin
      @(negedge clk);
      if (stalled) begin
        n_chk++;
        if (m_vld[k] !== 1'b1 || m_dat[k] !== hd || m_last[k] !== hl) begin
          n_fail++;
          $display("FAIL stall_hold: inst %0d got vld=%b dat=%h last=%b, required vld=1 dat=%h last=%b",
                   k, m_vld[k], m_dat[k], m_last[k], hd, hl);
        end
      end
      if (m_vld[k] === 1'b1 && m_rdy[k] === 1'b1) begin
        got_d.push_back(m_dat[k]);
        got_l.push_back(m_last[k]);
      end
      stalled = (m_vld[k] === 1'b1) && (m_rdy[k] === 1'b0);
      hd = m_dat[k];
      hl = m_last[k];
      @(posedge clk); #1;
      cyc++;
      case (mode)
        0:       m_rdy[k] = 1'b1;
        1:       m_rdy[k] = (cyc % 4 == 0);
        default: m_rdy[k] = 1'($urandom_range(0, 1));
      endcase
    end
    m_rdy[k] = 1'b1;
    if (got_d.size() < n) begin
      n_chk++; n_fail++;
      $display("FAIL collect_timeout: inst %0d got %0d outputs, required %0d", k, got_d.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (s_rdy[k] !== 1'b0)   begin n_fail++; $display("FAIL reset_s_rdy: inst %0d got %b required 0", k, s_rdy[k]); end
      n_chk++; if (m_vld[k] !== 1'b0)   begin n_fail++; $display("FAIL reset_m_vld: inst %0d got %b required 0", k, m_vld[k]); end
      n_chk++; if (m_dat[k] !== 32'h0)  begin n_fail++; $display("FAIL reset_m_dat: inst %0d got %h required 0", k, m_dat[k]); end
      n_chk++; if (m_last[k] !== 1'b0)  begin n_fail++; $display("FAIL reset_m_last: inst %0d got %b required 0", k, m_last[k]); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Cycle-exact: output must appear right after the edge accepting the completing beat.
  task automatic test_frame_4x4();
    logic [31:0] exp4 [4];
    bit          ev;
    int          o;
    exp4 = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
    o = 0;
    m_rdy[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_vld[0] = 1'b1;
      s_dat[0] = int2f(i + 1);
      @(negedge clk);
      n_chk++;
      if (s_rdy[0] !== 1'b1) begin n_fail++; $display("FAIL frame4_ready: beat %0d got %b required 1", i, s_rdy[0]); end
      @(posedge clk); #1;
      ev = ((i % 4) % 2 == 1) && ((i / 4) % 2 == 1);
      n_chk++;
      if (m_vld[0] !== ev) begin n_fail++; $display("FAIL frame4_vld: beat %0d got %b required %b", i, m_vld[0], ev); end
      if (ev) begin
        n_chk++;
        if (m_dat[0] !== exp4[o]) begin n_fail++; $display("FAIL frame4_dat: out %0d got %h required %h", o, m_dat[0], exp4[o]); end
        n_chk++;
        if (m_last[0] !== (o == 3)) begin n_fail++; $display("FAIL frame4_last: out %0d got %b required %b", o, m_last[0], (o == 3)); end
        o++;
      end
    end
    s_vld[0] = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (m_vld[0] !== 1'b0) begin n_fail++; $display("FAIL frame4_drain: got vld %b required 0", m_vld[0]); end
  endtask

  task automatic test_signed_zero_nan();
    logic [31:0] v [$];
    logic [31:0] ex [4];
    v = '{32'hC040_0000, 32'hBF80_0000, 32'h0000_0000, 32'h8000_0000,
          32'hC000_0000, 32'h8000_0000, 32'hC0A0_0000, 32'hC0E0_0000,
          32'h7F80_0000, 32'h3F80_0000, 32'hFFC0_0000, 32'hFF80_0000,
          32'h4000_0000, 32'h7FC0_0000, 32'hBF80_0000, 32'hC000_0000};
    ex = '{32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'hBF80_0000};
    fork
      drive(0, v, 0);
      collect(0, 4, 0);
    join
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ex[i]) begin n_fail++; $display("FAIL fp_order: out %0d got %h required %h", i, got_d[i], ex[i]); end
    end
  endtask

  task automatic test_odd_size();
    logic [31:0] v [$];
    logic [31:0] ex [4];
    ex = '{32'h40E0_0000, 32'h4110_0000, 32'h4188_0000, 32'h4198_0000};
    for (int f = 0; f < 2; f++)
      for (int i = 1; i <= 25; i++) v.push_back(int2f(i));
    fork
      drive(1, v, 0);
      collect(1, 8, 0);
    join
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ex[i % 4]) begin n_fail++; $display("FAIL odd_dat: out %0d got %h required %h", i, got_d[i], ex[i % 4]); end
      n_chk++;
      if (got_l[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL odd_last: out %0d got %b required %b", i, got_l[i], (i % 4 == 3)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v [$];
    logic [31:0] ex [4];
    ex = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
    for (int i = 1; i <= 16; i++) v.push_back(int2f(i));
    fork
      drive(0, v, 0);
      collect(0, 4, 1);
    join
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ex[i] || got_l[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL bp_out: out %0d got %h/%b required %h/%b", i, got_d[i], got_l[i], ex[i], (i == 3));
      end
    end
    @(negedge clk);
    n_chk++;
    if (m_vld[0] !== 1'b0) begin n_fail++; $display("FAIL bp_extra: got vld %b required 0", m_vld[0]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v [$];
    logic [31:0] ex [4];
    bit          extra;
    ex = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
    for (int i = 0; i < 9; i++) v.push_back(int2f(100 + i));
    m_rdy[0] = 1'b1;
    drive(0, v, 0);
    #1 rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_vld[0] !== 1'b0 || s_rdy[0] !== 1'b0 || m_dat[0] !== 32'h0 || m_last[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_state: got vld=%b rdy=%b dat=%h last=%b required all 0", m_vld[0], s_rdy[0], m_dat[0], m_last[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    v.delete();
    for (int i = 1; i <= 16; i++) v.push_back(int2f(i));
    fork
      drive(0, v, 0);
      collect(0, 4, 0);
    join
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== ex[i] || got_l[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL midrst_out: out %0d got %h/%b required %h/%b", i, got_d[i], got_l[i], ex[i], (i == 3));
      end
    end
    extra = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (m_vld[0] === 1'b1) extra = 1'b1;
    end
    n_chk++;
    if (extra) begin n_fail++; $display("FAIL midrst_extra: got extra output, required none"); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] v [$];
    logic [31:0] ex [$];
    bit          exl [$];
    logic [31:0] best;
    logic [31:0] x;
    int          base;
    int          lasts;
    for (int i = 0; i < 2 * 42; i++) v.push_back($urandom());
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          base = f * 42 + (2 * r) * 7 + 2 * c;
          best = v[base];
          for (int j = 1; j < 4; j++) begin
            x = v[base + (j / 2) * 7 + (j % 2)];
            if (okey(x) > okey(best)) best = x;
          end
          ex.push_back(best);
          exl.push_back(r == 2 && c == 2);
        end
    fork
      drive(2, v, 30);
      collect(2, 18, 2);
    join
    lasts = 0;
    for (int i = 0; i < 18 && i < got_d.size(); i++) begin
      if (got_l[i]) lasts++;
      n_chk++;
      if (got_d[i] !== ex[i] || got_l[i] !== exl[i]) begin
        n_fail++;
        $display("FAIL rand_out: out %0d got %h/%b required %h/%b", i, got_d[i], got_l[i], ex[i], exl[i]);
      end
    end
    n_chk++;
    if (lasts != 2) begin n_fail++; $display("FAIL rand_tlast_count: got %0d required 2", lasts); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      s_dat[k] = '0;
      s_vld[k] = 1'b0;
      m_rdy[k] = 1'b1;
    end
    test_reset();
    test_frame_4x4();
    test_signed_zero_nan();
    test_odd_size();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_maxpool_fp_2x2.md
AXIS_MAXPOOL_FP_2X2 -- requirements
Module: axis_maxpool_fp_2x2

Interface
REQ-001 The block SHALL have parameter IMG_W, default 638, input frame width in pixels (>=2).
REQ-002 The block SHALL have parameter IMG_H, default 478, input frame height in rows (>=2).
REQ-003 The block SHALL have port s_axis_aclk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port s_axis_aresetn, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port s_axis_tdata, input, 32, IEEE-754 single pixel from the 3x3 convolution output stream.
REQ-006 The block SHALL have port s_axis_tvalid, input, 1, input beat valid.
REQ-007 The block SHALL have port s_axis_tready, output, 1, input beat accepted when high with tvalid at a rising edge.
REQ-008 The block SHALL have port m_axis_tdata, output, 32, pooled IEEE-754 single pixel.
REQ-009 The block SHALL have port m_axis_tvalid, output, 1, output beat valid.
REQ-010 The block SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-011 The block SHALL have port m_axis_tlast, output, 1, marks the final pooled pixel of a frame.

Function
REQ-012 Input SHALL be raster order: IMG_W beats per row, IMG_H rows per frame, frames back-to-back with no separator.
REQ-013 Output SHALL be OUT_W = floor(IMG_W/2) by OUT_H = floor(IMG_H/2), in raster order; each pixel is the max of input rows 2r..2r+1 and columns 2c..2c+1.
REQ-014 Odd IMG_W: the last column of every row SHALL be accepted and discarded. Odd IMG_H: the last row SHALL be accepted and discarded, with no output.
REQ-015 Column counter (0..IMG_W-1) and row counter (0..IMG_H-1) SHALL advance only on accepted beats; column wraps to 0 and increments row; row wraps to 0 after IMG_W*IMG_H beats.
REQ-016 Even column beat: hold the pixel in a pair register.
REQ-017 Odd column beat in an even row: write max(pair register, beat) to line-buffer entry col/2. The line buffer holds OUT_W entries of 32 bits.
REQ-018 Odd column beat in an odd row: load max(pair register, beat, linebuf[col/2]) into the output register and set m_axis_tvalid.
REQ-019 Latency SHALL be 1 cycle: m_axis_tvalid rises on the edge that accepts the completing beat.
REQ-020 Float max SHALL compare the key k(x) = x with bit31 set if x[31]=0, else ~x, as unsigned; the larger key wins.
REQ-021 Consequences of REQ-020: +0 SHALL beat -0, and NaNs order by key, with no special handling.
REQ-022 On equal keys the earlier operand SHALL be kept; the result is bit-identical anyway.
REQ-023 s_axis_tready SHALL equal (~m_axis_tvalid | m_axis_tready) and be 0 while in reset.
REQ-024 A simultaneous output drain and new completing beat in one cycle SHALL reload the output register with no bubble, giving full throughput at 1 beat per cycle.
REQ-025 m_axis_tdata and m_axis_tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-026 m_axis_tvalid SHALL clear on a handshake with no new completing beat.
REQ-027 m_axis_tlast SHALL be 1 exactly with the output of pooled row OUT_H-1, column OUT_W-1, and 0 otherwise.
REQ-028 Non-completing beats SHALL be accepted whenever s_axis_tready=1, even though they produce no output.

Reset
REQ-029 While s_axis_aresetn=0, all of the following SHALL be 0: m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, the counters, and the pair register.
REQ-030 Line buffer contents SHALL NOT be reset; they are always written before they are read.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first accepted beat after release is row 0, column 0.

Verification
REQ-032 Test IMG_W=4, IMG_H=4 with input 1.0..16.0 (0x3F800000..), tready=1 -> 4 outputs 6.0, 8.0, 14.0, 16.0; tlast only on 16.0.
REQ-033 Test a 2x2 window {-3.0, -1.0, -2.0, -0.0 (0x80000000)} -> 0x80000000. Test window {+0.0, -0.0, -5.0, -7.0} -> 0x00000000.
REQ-034 Test IMG_W=5, IMG_H=5 with values 1..25 -> 4 outputs 7, 9, 17, 19 (as floats); column 4 and row 4 are consumed, and the next frame starts correctly.
REQ-035 Test the 4x4 frame with m_axis_tready toggling 1 cycle high / 3 cycles low -> identical output sequence; tdata stable while stalled; no beat lost or duplicated.
REQ-036 Test two back-to-back 638x478 frames with random floats -> 2x76241 outputs match the software model; exactly 2 tlast pulses.
REQ-037 Test reset asserted after 9 beats of a 4x4 frame, then a full frame -> only that frame's 4 correct outputs appear.
